// File: rtl/image_receiver.sv
// UART 8N1 receiver and pixel frame reassembler feeding a frame-buffer write port.
// Ports: clk, rst (sync high), uart_in -> wr_en/wr_address/wr_data, frame_done, frame_error, receiving. Optional macro: IMAGE_RX_TIMEOUT_EN.
module image_receiver #(
  parameter int NUM_PIXELS     = 76800,
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_in,
  output logic        wr_en,
  output logic [16:0] wr_address,
  output logic [11:0] wr_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        receiving
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] DATA_HI = 2'd1;
  localparam logic [1:0] DATA_LO = 2'd2;

  logic       s1, s2, rx_d;
  logic [1:0] rx_state;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  logic [1:0]  state;
  logic [7:0]  prev;
  logic [3:0]  hi_nib;
  logic [16:0] pix_addr;
  logic        timeout;

  // Edge detector resets low so a line held low across reset
  // must return high before a start bit is recognised.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rx_d <= 1'b0;
    end else begin
      s1   <= uart_in;
      s2   <= s1;
      rx_d <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == 16'(HALF - 1)) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == 16'(CPB - 1)) begin
            cnt     <= '0;
            shreg   <= {s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt == 16'(CPB - 1)) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (s2) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef IMAGE_RX_TIMEOUT_EN
  logic [31:0] gap;

  always_ff @(posedge clk) begin
    if (rst || state == HUNT || byte_valid) gap <= '0;
    else gap <= gap + 32'd1;
  end

  assign timeout = (state != HUNT) && !byte_valid && !frame_err &&
                   (gap == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      prev        <= 8'hFF;
      hi_nib      <= '0;
      pix_addr    <= '0;
      wr_en       <= 1'b0;
      wr_address  <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        HUNT: begin
          if (byte_valid) begin
            prev <= rx_byte;
            if (prev == 8'h00 && rx_byte == 8'h0A) begin
              state    <= DATA_HI;
              pix_addr <= '0;
            end
          end
        end
        DATA_HI: begin
          if (frame_err || timeout ||
              (byte_valid && rx_byte[7:4] != 4'h0)) begin
            frame_error <= 1'b1;
            state       <= HUNT;
            prev        <= 8'hFF;
          end else if (byte_valid) begin
            hi_nib <= rx_byte[3:0];
            state  <= DATA_LO;
          end
        end
        default: begin
          if (frame_err || timeout) begin
            frame_error <= 1'b1;
            state       <= HUNT;
            prev        <= 8'hFF;
          end else if (byte_valid) begin
            wr_en      <= 1'b1;
            wr_address <= pix_addr;
            wr_data    <= {hi_nib, rx_byte};
            pix_addr   <= pix_addr + 17'd1;
            if (pix_addr == 17'(NUM_PIXELS - 1)) begin
              frame_done <= 1'b1;
              state      <= HUNT;
              prev       <= 8'hFF;
            end else begin
              state <= DATA_HI;
            end
          end
        end
      endcase
    end
  end

  assign receiving = (state != HUNT);

endmodule

// File: tb/tb_image_receiver.sv
// Directed bench for image_receiver: UART frames, marker hunt, errors, reset.
// Runs with CLKS_PER_BIT=16, NUM_PIXELS=4, TIMEOUT_CYCLES=1000.
module tb_image_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_in;
  logic        wr_en;
  logic [16:0] wr_address;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        frame_error;
  logic        receiving;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int clash = 0;

  typedef struct {
    logic [16:0] a;
    logic [11:0] d;
    logic        done;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [11:0] pix;
    logic [16:0] exp_addr;
    logic [11:0] exp_data;
    logic        exp_done;
  } vec_t;
  vec_t tbl[4];

  image_receiver #(
    .NUM_PIXELS(4),
    .CLK_FREQ(1600000),
    .BAUD_RATE(100000),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_in(uart_in),
    .wr_en(wr_en),
    .wr_address(wr_address),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .receiving(receiving)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back('{wr_address, wr_data, frame_done});
    if (frame_error) err_pulses++;
    if (frame_error && wr_en) clash++;
    if (frame_done && !wr_en) clash++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (16) @(negedge clk);
    end
    uart_in = stop;
    repeat (16) @(negedge clk);
    idle(6);
  endtask

  task automatic send_pixel(input logic [11:0] p);
    send_byte({4'h0, p[11:8]}, 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic send_marker();
    send_byte(8'h00, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  task automatic expect_wr(input string nm, input int a,
                           input int d, input int done);
    wr_t w;
    chk({nm, "_cnt"}, wq.size(), 1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk({nm, "_addr"}, int'(w.a), a);
      chk({nm, "_data"}, int'(w.d), d);
      chk({nm, "_done"}, int'(w.done), done);
    end
    wq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{12'hABC, 17'd0, 12'hABC, 1'b0};
    tbl[1] = '{12'h123, 17'd1, 12'h123, 1'b0};
    tbl[2] = '{12'h000, 17'd2, 12'h000, 1'b0};
    tbl[3] = '{12'hFFF, 17'd3, 12'hFFF, 1'b1};

    uart_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr", int'(wr_address), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(frame_error), 0);
    chk("rst_recv", int'(receiving), 0);
    rst = 1'b0;
    idle(4);

    // Full frame, table driven
    send_marker();
    chk("ff_recv", int'(receiving), 1);
    for (int i = 0; i < 4; i++) begin
      send_pixel(tbl[i].pix);
      expect_wr($sformatf("ff%0d", i), int'(tbl[i].exp_addr),
                int'(tbl[i].exp_data), int'(tbl[i].exp_done));
    end
    chk("ff_err", err_pulses, 0);
    chk("ff_recv_end", int'(receiving), 0);

    // Marker hunt with noise
    send_byte(8'h55, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("hunt_recv", int'(receiving), 0);
    send_byte(8'h0A, 1'b1);
    chk("hunt_nowr", wq.size(), 0);
    chk("hunt_recv2", int'(receiving), 1);
    send_pixel(12'h5A5);
    expect_wr("hunt", 0, 'h5A5, 0);

    // Reset after two pixels
    send_pixel(12'h246);
    expect_wr("pre_rst", 1, 'h246, 0);
    do_reset();
    chk("mr_wr_en", int'(wr_en), 0);
    chk("mr_addr", int'(wr_address), 0);
    chk("mr_data", int'(wr_data), 0);
    chk("mr_recv", int'(receiving), 0);
    idle(4);

    // Glitch: short low pulse
    uart_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(200);
    chk("glitch_nowr", wq.size(), 0);
    chk("glitch_err", err_pulses, 0);
    chk("glitch_recv", int'(receiving), 0);

    send_marker();
    send_pixel(12'h777);
    expect_wr("post_rst", 0, 'h777, 0);
    do_reset();
    idle(4);

    // Bad high nibble
    send_marker();
    send_byte(8'h31, 1'b1);
    chk("nib_err", err_pulses, 1);
    chk("nib_recv", int'(receiving), 0);
    send_byte(8'h22, 1'b1);
    chk("nib_nowr", wq.size(), 0);
    send_marker();
    for (int i = 0; i < 4; i++) begin
      send_pixel(tbl[i].pix);
      expect_wr($sformatf("nib_ff%0d", i), int'(tbl[i].exp_addr),
                int'(tbl[i].exp_data), int'(tbl[i].exp_done));
    end
    chk("nib_err_end", err_pulses, 1);

    // Stop-bit error mid-frame
    send_marker();
    send_pixel(12'h111);
    expect_wr("stop", 0, 'h111, 0);
    send_byte(8'h01, 1'b0);
    chk("stop_err", err_pulses, 2);
    chk("stop_recv", int'(receiving), 0);
    chk("stop_nowr", wq.size(), 0);

    // Long idle gap inside a frame
    send_marker();
    idle(1200);
`ifdef IMAGE_RX_TIMEOUT_EN
    chk("to_err", err_pulses, 3);
    chk("to_recv", int'(receiving), 0);
`else
    chk("to_err", err_pulses, 2);
    chk("to_recv", int'(receiving), 1);
    send_pixel(12'h0F0);
    expect_wr("to", 0, 'h0F0, 0);
`endif

    chk("no_clash", clash, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
